// File: rtl/dds_fir_pkg.sv
// dds_fir_pkg: shared widths, quarter-wave sine table and FIR coefficients.
package dds_fir_pkg;
   localparam int SAMPLE_W = 16;
   localparam int COEF_W   = 16;
   localparam int ACC_W    = 36;
   localparam int OUT_W    = 32;
   localparam int NTAPS    = 16;
   localparam int LAT      = 6;
   // products are summed in groups of four inside the multiply stage
   localparam int NGRP     = (NTAPS + 3) / 4;
   localparam int AMP      = 32767;

   typedef logic [0:255][SAMPLE_W-1:0] sine_tab_t;

   // registered LUT output: magnitude plus pending negation for quadrants 2/3
   typedef struct packed {
      logic                neg;
      logic [SAMPLE_W-1:0] mag;
   } lut_t;

   // round(AMP*sin(2*pi*i/1024)) evaluated at elaboration with a Taylor series
   function automatic logic [SAMPLE_W-1:0] sine_q(input int i);
      real x, term, s;
      x    = 3.14159265358979323846 * real'(i) / 512.0;
      term = x;
      s    = x;
      for (int n = 1; n < 12; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         s    = s + term;
      end
      return SAMPLE_W'($rtoi(real'(AMP) * s + 0.5));
   endfunction

   function automatic sine_tab_t gen_sine();
      sine_tab_t t;
      for (int i = 0; i < 256; i++) t[i] = sine_q(i);
      return t;
   endfunction

   localparam sine_tab_t SINE_Q = gen_sine();

   // symmetric Q15 low-pass, unity DC gain
   localparam logic signed [COEF_W-1:0] FIR_COEF [0:NTAPS-1] = '{
      16'sd128,  16'sd384,  16'sd896,  16'sd1536, 16'sd2304, 16'sd3072, 16'sd3840, 16'sd4224,
      16'sd4224, 16'sd3840, 16'sd3072, 16'sd2304, 16'sd1536, 16'sd896,  16'sd384,  16'sd128
   };

   function automatic int sum_coef();
      int s;
      s = 0;
      for (int i = 0; i < NTAPS; i++) s += int'(FIR_COEF[i]);
      return s;
   endfunction

   localparam int SUM_COEF = sum_coef();
endpackage

// File: rtl/dds_fir_gen_sine.sv
// dds_sine: phase accumulator, quarter-wave sine lookup and quadrant fold.
// Sample k leaves on 'sample' after edge k+3 (phase reg, LUT read, fold).
module dds_sine import dds_fir_pkg::*; #(
   parameter logic [31:0] PINC      = 32'h0100_0000,
   parameter logic [31:0] PHASE_OFF = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic signed [SAMPLE_W-1:0] sample
);
   logic [31:0]         acc_q, acc_d;
   logic [9:0]          phase_q, phase_d;
   lut_t                lut_q, lut_d;
   logic [SAMPLE_W-1:0] samp_q, samp_d;
   logic [8:0]          qidx;

   // next state of each sine pipeline stage
   always_comb begin
      acc_d     = acc_q + PINC;
      phase_d   = acc_q[31:22];
      // odd quadrants walk the quarter table backwards; index 256 is the peak
      qidx      = phase_q[8] ? 9'd256 - {1'b0, phase_q[7:0]} : {1'b0, phase_q[7:0]};
      lut_d.neg = phase_q[9];
      lut_d.mag = qidx[8] ? SAMPLE_W'(AMP) : SINE_Q[qidx[7:0]];
      samp_d    = lut_q.neg ? -lut_q.mag : lut_q.mag;
   end

   // pipeline registers; phase register starts at 0 so pre-start samples are 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= PHASE_OFF;
         phase_q <= '0;
         lut_q   <= '0;
         samp_q  <= '0;
      end else begin
         acc_q   <= acc_d;
         phase_q <= phase_d;
         lut_q   <= lut_d;
         samp_q  <= samp_d;
      end
   end

   assign sample = samp_q;
endmodule

// File: rtl/dds_fir_gen.sv
// dds_fir_gen: free-running DDS sine source into a fixed low-pass FIR,
// streamed out one sample per clock with a valid flag once the taps are full.
module dds_fir_gen import dds_fir_pkg::*; #(
   parameter logic [31:0] PINC      = 32'h0100_0000,
   parameter logic [31:0] PHASE_OFF = 32'h0000_0000
) (
   input  logic             aclk_0,
   input  logic             aresetn_0,
   output logic [OUT_W-1:0] m_axis_data_tdata_0,
   output logic             M_AXIS_DATA_0_tvalid
);
   // first output built from a completely filled delay line
   localparam int FILL  = NTAPS - 1 + LAT;
   localparam int CNT_W = $clog2(FILL + 1);

   logic signed [SAMPLE_W-1:0]        samp;
   logic signed [SAMPLE_W-1:0]        dl_q [NTAPS];
   logic signed [SAMPLE_W-1:0]        dl_d [NTAPS];
   logic signed [COEF_W+SAMPLE_W-1:0] prod [NTAPS];
   logic signed [ACC_W-1:0]           grp_q [NGRP];
   logic signed [ACC_W-1:0]           grp_d [NGRP];
   logic signed [ACC_W-1:0]           y_q, y_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   logic                              vld_q, vld_d;
   logic                              unused_hi;

   dds_sine #(.PINC(PINC), .PHASE_OFF(PHASE_OFF)) u_sine (
      .clk    (aclk_0),
      .rst_n  (aresetn_0),
      .sample (samp)
   );

   // delay line shift: newest sample in tap 0
   always_comb begin
      dl_d[0] = samp;
      for (int i = 1; i < NTAPS; i++) dl_d[i] = dl_q[i-1];
   end

   // full-precision tap products
   always_comb begin
      for (int i = 0; i < NTAPS; i++) prod[i] = FIR_COEF[i] * dl_q[i];
   end

   // first two adder-tree levels, registered with the multiply stage
   always_comb begin
      for (int g = 0; g < NGRP; g++) begin
         grp_d[g] = '0;
         for (int j = 0; j < 4; j++)
            if (4 * g + j < NTAPS) grp_d[g] = grp_d[g] + ACC_W'(prod[4 * g + j]);
      end
   end

   // remaining adder-tree levels
   always_comb begin
      y_d = '0;
      for (int g = 0; g < NGRP; g++) y_d = y_d + grp_q[g];
   end

   // fill counter saturates; valid latches once the full-line sample arrives
   always_comb begin
      cnt_d = (cnt_q == CNT_W'(FILL)) ? cnt_q : cnt_q + 1'b1;
      vld_d = vld_q | (cnt_q == CNT_W'(FILL - 1));
   end

   // FIR state and output registers
   always_ff @(posedge aclk_0 or negedge aresetn_0) begin
      if (!aresetn_0) begin
         dl_q  <= '{default: '0};
         grp_q <= '{default: '0};
         y_q   <= '0;
         cnt_q <= '0;
         vld_q <= 1'b0;
      end else begin
         dl_q  <= dl_d;
         grp_q <= grp_d;
         y_q   <= y_d;
         cnt_q <= cnt_d;
         vld_q <= vld_d;
      end
   end

   // coefficient budget keeps the sum inside OUT_W, so the top bits are dropped
   assign unused_hi            = ^y_q[ACC_W-1:OUT_W];
   assign m_axis_data_tdata_0  = y_q[OUT_W-1:0];
   assign M_AXIS_DATA_0_tvalid = vld_q;
endmodule

// File: tb/tb_dds_fir_gen.sv
// tb_dds_fir_gen: four instances (default tone, DC max, DC min, zero) on a
// shared clock/reset, compared against a floating-point sine + convolution model.
module tb_dds_fir_gen;
   localparam int          NT        = 16;
   localparam int          LATENCY   = 6;
   localparam int          FIRST_VLD = 21;
   localparam int          NEDGE     = 1040;
   localparam logic [31:0] PINC_DEF  = 32'h0100_0000;
   localparam longint      PEAK_MAX  = 64'd32767 * 64'd32768;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic [31:0] td_def, td_max, td_min, td_zero;
   logic        tv_def, tv_max, tv_min, tv_zero;

   dds_fir_gen #(.PINC(PINC_DEF), .PHASE_OFF(32'h0000_0000)) u_def (
      .aclk_0(clk), .aresetn_0(rstn), .m_axis_data_tdata_0(td_def), .M_AXIS_DATA_0_tvalid(tv_def));
   dds_fir_gen #(.PINC(32'h0), .PHASE_OFF(32'h4000_0000)) u_max (
      .aclk_0(clk), .aresetn_0(rstn), .m_axis_data_tdata_0(td_max), .M_AXIS_DATA_0_tvalid(tv_max));
   dds_fir_gen #(.PINC(32'h0), .PHASE_OFF(32'hC000_0000)) u_min (
      .aclk_0(clk), .aresetn_0(rstn), .m_axis_data_tdata_0(td_min), .M_AXIS_DATA_0_tvalid(tv_min));
   dds_fir_gen #(.PINC(32'h0), .PHASE_OFF(32'h0000_0000)) u_zero (
      .aclk_0(clk), .aresetn_0(rstn), .m_axis_data_tdata_0(td_zero), .M_AXIS_DATA_0_tvalid(tv_zero));

   int coef [NT] = '{128, 384, 896, 1536, 2304, 3072, 3840, 4224,
                     4224, 3840, 3072, 2304, 1536, 896, 384, 128};
   int          s_ref [NEDGE+1];
   longint      y_ref [NEDGE+1];
   logic [31:0] run1_td [NEDGE+1];
   logic        run1_tv [NEDGE+1];
   int          checks = 0;
   int          fails  = 0;
   longint      peak   = 0;

   // full-wave sine sample straight from the definition, no table folding
   function automatic int ref_sample(input int k);
      logic [31:0] ph;
      int          a;
      real         r;
      ph = 32'(k) * PINC_DEF;
      a  = int'(ph[31:22]);
      r  = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(a) / 1024.0);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_td_def"},  64'(td_def),  64'h0);
      chk({tag, "_td_max"},  64'(td_max),  64'h0);
      chk({tag, "_td_min"},  64'(td_min),  64'h0);
      chk({tag, "_td_zero"}, 64'(td_zero), 64'h0);
      chk({tag, "_tv_def"},  64'(tv_def),  64'h0);
      chk({tag, "_tv_max"},  64'(tv_max),  64'h0);
      chk({tag, "_tv_min"},  64'(tv_min),  64'h0);
      chk({tag, "_tv_zero"}, 64'(tv_zero), 64'h0);
   endtask

   // all checks for the state after edge e; optionally record or compare to run 1
   task automatic edge_checks(input int e, input bit rec, input bit cmp);
      logic [31:0] e32;
      longint      v;
      chk($sformatf("tv_def@%0d", e), 64'(tv_def), 64'(e >= FIRST_VLD));
      chk($sformatf("tv_max@%0d", e), 64'(tv_max), 64'(e >= FIRST_VLD));
      chk($sformatf("td_zero@%0d", e), 64'(td_zero), 64'h0);
      if (e >= FIRST_VLD) begin
         e32 = 32'(y_ref[e - LATENCY]);
         chk($sformatf("td_def@%0d", e), 64'(td_def), 64'(e32));
         chk($sformatf("td_dcmax@%0d", e), 64'(td_max), 64'(32'h3FFF_8000));
         chk($sformatf("td_dcmin@%0d", e), 64'(td_min), 64'(32'hC000_8000));
         v = longint'($signed(td_def));
         if (v < 0) v = -v;
         if (v > peak) peak = v;
      end
      if (rec) begin
         run1_td[e] = td_def;
         run1_tv[e] = tv_def;
      end
      if (cmp) begin
         chk($sformatf("restart_td@%0d", e), 64'(td_def), 64'(run1_td[e]));
         chk($sformatf("restart_tv@%0d", e), 64'(tv_def), 64'(run1_tv[e]));
      end
   endtask

   initial begin
      for (int k = 0; k <= NEDGE; k++) s_ref[k] = ref_sample(k);
      for (int k = 0; k <= NEDGE; k++) begin
         y_ref[k] = 0;
         for (int i = 0; i < NT; i++)
            if (k - i >= 0) y_ref[k] += longint'(coef[i]) * longint'(s_ref[k - i]);
      end

      // reset held with and without clocks
      rstn = 1'b0;
      #2;
      reset_checks("rst_async");
      repeat (3) @(negedge clk);
      reset_checks("rst_clocked");

      // run 1: golden comparison over the full window, outputs recorded
      rstn = 1'b1;
      for (int e = 1; e <= NEDGE; e++) begin
         @(negedge clk);
         edge_checks(e, 1'b1, 1'b0);
      end
      chk("peak_bound", 64'(peak <= PEAK_MAX), 64'h1);

      // run 2: fresh reset, stream up to edge 100
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      for (int e = 1; e <= 100; e++) begin
         @(negedge clk);
         edge_checks(e, 1'b0, 1'b1);
      end

      // mid-stream reset: outputs must drop without a clock edge
      rstn = 1'b0;
      #1;
      reset_checks("rst_mid_now");
      repeat (3) @(negedge clk);
      reset_checks("rst_mid_held");

      // run 3: restart must repeat run 1 and the model
      rstn = 1'b1;
      for (int e = 1; e <= 300; e++) begin
         @(negedge clk);
         edge_checks(e, 1'b0, 1'b1);
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule

// File: doc/dds_fir_gen.md
# dds_fir_gen

Self-running direct digital synthesis (DDS) sine source feeding a fixed-coefficient low-pass FIR filter. It presents filtered samples on an AXI4-Stream-style master output with no tready. The block sits at the front of the waveform-generator datapath, and its output stream feeds the DAC/arbitrary-waveform back end.

## Interface
- PINC, 32'h0100_0000, phase increment per clock (output frequency = PINC·f_clk/2^32).
- PHASE_OFF, 32'h0000_0000, phase accumulator value on reset.
- NTAPS, 16, FIR tap count (even, 2..32).
- aclk_0  in  1  sole clock; all state updates on its rising edge.
- aresetn_0  in  1  asynchronous, active-low reset for all registers.
- m_axis_data_tdata_0  out  32  signed filtered sample (two's complement).
- M_AXIS_DATA_0_tvalid  out  1  high when tdata carries a valid filtered sample.

## Operation
- Phase accumulator (32 bit):
  - Reset value PHASE_OFF.
  - Adds PINC every cycle, wrapping modulo 2^32.
  - Sample index k has phase PHASE_OFF + k·PINC.
- Sine LUT (quarter-wave, 256 × 16-bit entries):
  - Address is phase[31:22], giving 1024 points per period.
  - Quadrant is taken from address bits [9:8]; the quarter index is folded for quadrants 1 and 3; the output is negated for quadrants 2 and 3.
  - Full-wave value = round(32767·sin(2π·a/1024)), so a=0 gives 0, a=256 gives 32767, a=512 gives 0, a=768 gives −32767.
  - Each quadrant therefore needs 257 points; the quarter table stores indices 0..255, and index 256 is a special case that returns 32767.
- FIR:
  - y[k] = Σ_{i=0}^{NTAPS−1} c[i]·s[k−i], with s[n<0]=0 (delay line cleared by reset).
  - 16×16 signed multiplies; sum carried at full precision in 36 bits.
  - tdata = y[k][31:0]. The coefficient set must satisfy Σ|c[i]| ≤ 65535, so y never exceeds 32 bits.
  - No rounding and no saturation.
- Default coefficients are a symmetric Q15 low-pass set with Σc[i] = 32768 (unity DC gain).
- No input stream and no backpressure. The block produces one sample per clock forever.

## Timing
- Reset (asynchronous, immediate):
  - tdata = 0, tvalid = 0, phase = PHASE_OFF.
  - Delay line, pipeline registers and the fill counter are cleared.
- Edge 1 is the first rising edge with aresetn_0 high.
- Pipeline latency LAT = 6 edges, so y[k] appears on tdata after edge k+LAT:
  - 1 edge: phase register.
  - 1 edge: LUT read.
  - 1 edge: fold/negate.
  - 1 edge: delay-line shift.
  - 1 edge: multiply.
  - 1 edge: two adder-tree levels.
  - For NTAPS=16 the adder tree needs 4 levels, so it is split over the multiply and sum stages (2 levels per cycle).
- tvalid:
  - Rises after edge (NTAPS−1)+LAT, which is 21 for the defaults. This is the first sample computed from a full delay line.
  - Then stays high every cycle until the next reset.
- tdata before tvalid: partial sums, not guaranteed. Consumers must ignore it.
- Reset asserted mid-stream: outputs drop on the next simulation delta (no clock needed). After release, the sequence restarts from k=0 with identical sample values.

## Structure
- Package dds_fir_pkg holds:
  - LUT constant SINE_Q[0:255];
  - coefficient array FIR_COEF[0:NTAPS−1] and its constant SUM_COEF;
  - widths SAMPLE_W=16, COEF_W=16, ACC_W=36, OUT_W=32;
  - LAT.
- One natural sub-module: dds_sine (phase accumulator + LUT + fold). The FIR stays in the top level.

## Test plan
- Reset/latency, default params:
  - tvalid=0 through edge 20 and 1 from edge 21.
  - tdata=0 while aresetn_0=0.
- DC max, PINC=0, PHASE_OFF=32'h4000_0000:
  - Every sample is 32767.
  - With tvalid=1, tdata = 32767·32768 = 32'h3FFF_8000.
- DC min, PINC=0, PHASE_OFF=32'hC000_0000: with tvalid=1, tdata = 32'hC000_8000 (−32767·32768).
- Zero, PINC=0, PHASE_OFF=0: tdata = 0 at all times.
- Default PINC (period 256 clocks), checked against a golden model over 1024 cycles:
  - tdata matches y[k] bit-exactly.
  - Peak magnitude ≤ 32767·Σ|c[i]|.
- Mid-stream reset:
  - Pull aresetn_0 low for 3 cycles at edge 100; tvalid falls immediately.
  - After release, the output sequence is identical to the first run.
